// File: rtl/alu_lane_scheduler.sv
// -----------------------------------------------------------------------------
// alu_lane_scheduler
//   Shares one ALU packet lane among four requesters. A round-robin arbiter
//   grants at most one requester per cycle (one operation in flight per
//   requester). The granted operation is registered onto the alu_* outputs.
//   A tag pipeline matches the lane's fixed result latency, so each result
//   is steered back to the requester that issued it.
//
// Ports
//   clock, reset          rising-edge clock, asynchronous active-low reset
//   req_valid/req_ready   per-requester handshake (4 bits each)
//   req_data1/req_data2   4 x 32-bit operands, requester i at [32i+31:32i]
//   req_command           4 x 2-bit command, same packing
//   alu_valid/alu_data1/alu_data2/alu_command   registered issue beat
//   alu_data/alu_response                       lane result inputs
//   resp_valid            one-hot, one-cycle result pulse per requester
//   resp_data/resp_response                     captured lane result
//   outstanding           per-requester in-flight flag
// -----------------------------------------------------------------------------
module alu_lane_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int ALU_LATENCY = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [3:0]   req_valid,
  output logic [3:0]   req_ready,
  input  logic [127:0] req_data1,
  input  logic [127:0] req_data2,
  input  logic [7:0]   req_command,
  output logic         alu_valid,
  output logic [31:0]  alu_data1,
  output logic [31:0]  alu_data2,
  output logic [1:0]   alu_command,
  input  logic [31:0]  alu_data,
  input  logic [1:0]   alu_response,
  output logic [3:0]   resp_valid,
  output logic [31:0]  resp_data,
  output logic [1:0]   resp_response,
  output logic [3:0]   outstanding
);

  logic [1:0] ptr;        // last granted requester
  logic [1:0] issue_id;   // requester owning the beat currently on the lane

  // alu_valid/issue_id form the entry stage; the ALU_LATENCY stages behind
  // it line up the final tag with the cycle the lane presents the result.
  logic [ALU_LATENCY-1:0] tag_v;
  logic [1:0]             tag_id [ALU_LATENCY];

  logic [3:0] eligible;
  logic       grant_hit;
  logic [1:0] grant_id;
  logic       handshake;
  logic       retire;
  logic [1:0] retire_id;
  logic [3:0] outstanding_next;

  assign eligible  = req_valid & ~outstanding;
  assign handshake = |(req_valid & req_ready);
  assign retire    = tag_v[ALU_LATENCY-1];
  assign retire_id = tag_id[ALU_LATENCY-1];

  // Round-robin search starting just after the last grant. The offset of
  // NUM_REQ wraps back onto ptr itself, so it is searched last.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would infer a latch.
    grant_hit = 1'b0;
    grant_id  = 2'd0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      if (!grant_hit && eligible[ptr + 2'(off)]) begin
        grant_hit = 1'b1;
        grant_id  = ptr + 2'(off);
      end
    end
    req_ready = grant_hit ? (4'b0001 << grant_id) : 4'b0000;
  end

  // Retire and issue never target the same requester (an outstanding
  // requester is not eligible), so clear-then-set is order independent.
  always_comb begin
    outstanding_next = outstanding;
    if (retire)    outstanding_next[retire_id] = 1'b0;
    if (handshake) outstanding_next[grant_id]  = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      // NOTE: the tag pipeline is reset (unlike a data store) because its
      // valid bits decide whether a result is delivered; stale tags after
      // reset would produce phantom responses.
      alu_valid     <= 1'b0;
      alu_data1     <= '0;
      alu_data2     <= '0;
      alu_command   <= '0;
      issue_id      <= '0;
      ptr           <= 2'd3;
      outstanding   <= '0;
      resp_valid    <= '0;
      resp_data     <= '0;
      resp_response <= '0;
      tag_v         <= '0;
      for (int i = 0; i < ALU_LATENCY; i++) tag_id[i] <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      if (handshake) begin
        alu_valid   <= 1'b1;
        alu_data1   <= req_data1[{grant_id, 5'd0} +: 32];
        alu_data2   <= req_data2[{grant_id, 5'd0} +: 32];
        alu_command <= req_command[{grant_id, 1'b0} +: 2];
        issue_id    <= grant_id;
        ptr         <= grant_id;
      end else begin
        alu_valid   <= 1'b0;
        alu_data1   <= '0;
        alu_data2   <= '0;
        alu_command <= '0;
        issue_id    <= '0;
      end

      tag_v[0]  <= alu_valid;
      tag_id[0] <= issue_id;
      for (int i = 1; i < ALU_LATENCY; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_id[i] <= tag_id[i-1];
      end

      if (retire) begin
        resp_valid    <= 4'b0001 << retire_id;
        resp_data     <= alu_data;
        resp_response <= alu_response;
      end else begin
        resp_valid    <= '0;
      end

      outstanding <= outstanding_next;
    end
  end

endmodule

// File: tb/tb_alu_lane_scheduler.sv
// -----------------------------------------------------------------------------
// tb_alu_lane_scheduler
//   Directed bench for alu_lane_scheduler. Two instances share the clock and
//   reset: dut (ALU_LATENCY=1) and dut4 (ALU_LATENCY=4). Each has a small
//   fixed-latency ALU model behind it; expected values are hand-computed.
// -----------------------------------------------------------------------------
module tb_alu_lane_scheduler;

  logic         clock = 1'b0;
  logic         reset = 1'b0;

  // Instance with ALU_LATENCY = 1
  logic [3:0]   req_valid = '0;
  logic [3:0]   req_ready;
  logic [127:0] req_data1 = '0;
  logic [127:0] req_data2 = '0;
  logic [7:0]   req_command = '0;
  logic         alu_valid;
  logic [31:0]  alu_data1, alu_data2;
  logic [1:0]   alu_command;
  logic [31:0]  alu_data;
  logic [1:0]   alu_response;
  logic [3:0]   resp_valid;
  logic [31:0]  resp_data;
  logic [1:0]   resp_response;
  logic [3:0]   outstanding;

  // Instance with ALU_LATENCY = 4
  logic [3:0]   req_valid_4 = '0;
  logic [3:0]   req_ready_4;
  logic [127:0] req_data1_4 = '0;
  logic [127:0] req_data2_4 = '0;
  logic [7:0]   req_command_4 = '0;
  logic         alu_valid_4;
  logic [31:0]  alu_data1_4, alu_data2_4;
  logic [1:0]   alu_command_4;
  logic [31:0]  alu_data_4;
  logic [1:0]   alu_response_4;
  logic [3:0]   resp_valid_4;
  logic [31:0]  resp_data_4;
  logic [1:0]   resp_response_4;
  logic [3:0]   outstanding_4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  alu_lane_scheduler #(.NUM_REQ(4), .ALU_LATENCY(1)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_data1(req_data1), .req_data2(req_data2), .req_command(req_command),
    .alu_valid(alu_valid), .alu_data1(alu_data1), .alu_data2(alu_data2),
    .alu_command(alu_command), .alu_data(alu_data), .alu_response(alu_response),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_response(resp_response),
    .outstanding(outstanding)
  );

  alu_lane_scheduler #(.NUM_REQ(4), .ALU_LATENCY(4)) dut4 (
    .clock(clock), .reset(reset),
    .req_valid(req_valid_4), .req_ready(req_ready_4),
    .req_data1(req_data1_4), .req_data2(req_data2_4), .req_command(req_command_4),
    .alu_valid(alu_valid_4), .alu_data1(alu_data1_4), .alu_data2(alu_data2_4),
    .alu_command(alu_command_4), .alu_data(alu_data_4), .alu_response(alu_response_4),
    .resp_valid(resp_valid_4), .resp_data(resp_data_4), .resp_response(resp_response_4),
    .outstanding(outstanding_4)
  );

  // ALU behaviour: the response code echoes the command so every code 0..3
  // can be produced on demand.
  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [1:0] cmd);
    case (cmd)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return a & b;
      default: return a ^ b;
    endcase
  endfunction

  // Lane model, latency 1: the beat seen at an edge is answered in the next cycle.
  logic        m1_v = 1'b0;
  logic [31:0] m1_a = '0, m1_b = '0;
  logic [1:0]  m1_c = '0;
  always @(posedge clock) begin
    m1_v <= alu_valid;
    m1_a <= alu_data1;
    m1_b <= alu_data2;
    m1_c <= alu_command;
  end
  assign alu_data     = m1_v ? alu_fn(m1_a, m1_b, m1_c) : 32'hDEAD_BEEF;
  assign alu_response = m1_v ? m1_c : 2'd0;

  // Lane model, latency 4.
  logic        m4_v [4];
  logic [31:0] m4_a [4];
  logic [31:0] m4_b [4];
  logic [1:0]  m4_c [4];
  initial for (int i = 0; i < 4; i++) begin
    m4_v[i] = 1'b0; m4_a[i] = '0; m4_b[i] = '0; m4_c[i] = '0;
  end
  always @(posedge clock) begin
    m4_v[0] <= alu_valid_4;
    m4_a[0] <= alu_data1_4;
    m4_b[0] <= alu_data2_4;
    m4_c[0] <= alu_command_4;
    for (int i = 1; i < 4; i++) begin
      m4_v[i] <= m4_v[i-1];
      m4_a[i] <= m4_a[i-1];
      m4_b[i] <= m4_b[i-1];
      m4_c[i] <= m4_c[i-1];
    end
  end
  assign alu_data_4     = m4_v[3] ? alu_fn(m4_a[3], m4_b[3], m4_c[3]) : 32'hDEAD_BEEF;
  assign alu_response_4 = m4_v[3] ? m4_c[3] : 2'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] d1, input logic [31:0] d2,
                         input logic [1:0] cmd);
    req_data1[32*i +: 32] = d1;
    req_data2[32*i +: 32] = d2;
    req_command[2*i +: 2] = cmd;
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    #2;
    reset = 1'b1;
    #1;
  endtask

  logic [3:0] fair_exp [8];
  logic [3:0] onehot;
  int         r;

  initial begin
    // ---------------- Reset state ----------------
    #3;
    check("rst_alu_valid",   32'(alu_valid), 32'd0);
    check("rst_alu_data1",   alu_data1, 32'd0);
    check("rst_outstanding", 32'(outstanding), 32'd0);
    check("rst_resp_valid",  32'(resp_valid), 32'd0);
    check("rst_resp_data",   resp_data, 32'd0);
    check("rst_resp_resp",   32'(resp_response), 32'd0);
    @(negedge clock);
    reset = 1'b1;

    // ---------------- Single request, latency 1 ----------------
    set_req(0, 32'h0000_0003, 32'h0000_0004, 2'd0);
    req_valid = 4'b0001;
    #1;
    check("single_ready", 32'(req_ready), 32'h1);
    tick();                                   // handshake edge E
    req_valid = 4'b0000;
    check("single_alu_valid", 32'(alu_valid), 32'd1);
    check("single_alu_d1",    alu_data1, 32'h3);
    check("single_alu_d2",    alu_data2, 32'h4);
    check("single_alu_cmd",   32'(alu_command), 32'd0);
    check("single_out_set",   32'(outstanding), 32'h1);
    check("single_no_resp",   32'(resp_valid), 32'd0);
    tick();                                   // E+1
    check("single_alu_idle",  32'(alu_valid), 32'd0);
    check("single_alu_d1_0",  alu_data1, 32'd0);
    check("single_no_resp2",  32'(resp_valid), 32'd0);
    tick();                                   // E+2: result captured
    check("single_resp_valid", 32'(resp_valid), 32'h1);
    check("single_resp_data",  resp_data, 32'h7);
    check("single_out_clr",    32'(outstanding), 32'd0);
    tick();
    check("single_resp_drop",  32'(resp_valid), 32'd0);
    check("single_resp_hold",  resp_data, 32'h7);

    // ---------------- All four requesters from reset ----------------
    for (int i = 0; i < 4; i++)
      set_req(i, 32'h100 * (i + 1), 32'(i + 5), 2'(i));
    req_valid = 4'b1111;
    pulse_reset();
    for (int c = 0; c < 12; c++) begin
      check("all_ready", 32'(req_ready), 32'(4'b0001 << (c % 4)));
      check("all_ready_not_busy", 32'(req_ready & outstanding), 32'd0);
      if (c >= 1)
        check("all_alu_d1", alu_data1, 32'h100 * ((c - 1) % 4 + 1));
      if (c >= 3) begin
        r = (c - 3) % 4;
        check("all_resp_valid", 32'(resp_valid), 32'(4'b0001 << r));
        check("all_resp_data",  resp_data, alu_fn(32'h100 * (r + 1), 32'(r + 5), 2'(r)));
        check("all_resp_resp",  32'(resp_response), 32'(r));
      end else begin
        check("all_resp_idle", 32'(resp_valid), 32'd0);
      end
      tick();
    end
    req_valid = 4'b0000;
    repeat (4) tick();

    // ---------------- Fairness: 1 and 3 contend, 0 joins ----------------
    pulse_reset();
    set_req(1, 32'd11, 32'd1, 2'd0);
    set_req(3, 32'd33, 32'd3, 2'd0);
    set_req(0, 32'd50, 32'd5, 2'd0);
    req_valid = 4'b0010;
    #1;
    check("fair_setup_ready", 32'(req_ready), 32'h2);
    tick();                                   // pointer now 1
    req_valid = 4'b0000;
    repeat (3) tick();
    check("fair_setup_idle", 32'(outstanding), 32'd0);
    fair_exp[0] = 4'b1000; fair_exp[1] = 4'b0010; fair_exp[2] = 4'b0000;
    fair_exp[3] = 4'b1000; fair_exp[4] = 4'b0010; fair_exp[5] = 4'b0000;
    fair_exp[6] = 4'b1000; fair_exp[7] = 4'b0001;
    req_valid = 4'b1010;
    for (int c = 0; c < 8; c++) begin
      if (c == 6) req_valid = 4'b1011;
      #1;
      check("fair_ready", 32'(req_ready), 32'(fair_exp[c]));
      tick();
    end
    req_valid = 4'b0000;
    repeat (4) tick();

    // ---------------- ALU_LATENCY = 4, requester 2 ----------------
    pulse_reset();
    req_data1_4[64 +: 32] = 32'd10;
    req_data2_4[64 +: 32] = 32'd3;
    req_command_4[4 +: 2] = 2'd1;
    req_valid_4 = 4'b0100;
    #1;
    check("lat4_ready", 32'(req_ready_4), 32'h4);
    tick();                                   // handshake edge E
    for (int k = 1; k <= 5; k++) begin
      tick();                                 // edge E+k
      if (k < 5) begin
        check("lat4_no_resp",  32'(resp_valid_4), 32'd0);
        check("lat4_blocked",  32'(req_ready_4), 32'd0);
        check("lat4_busy",     32'(outstanding_4), 32'h4);
      end else begin
        check("lat4_resp_valid", 32'(resp_valid_4), 32'h4);
        check("lat4_resp_data",  resp_data_4, 32'd7);
        check("lat4_resp_resp",  32'(resp_response_4), 32'd1);
        check("lat4_out_clr",    32'(outstanding_4), 32'd0);
        check("lat4_regrant",    32'(req_ready_4), 32'h4);
      end
    end
    req_valid_4 = 4'b0000;
    tick();

    // ---------------- Reset mid-operation ----------------
    pulse_reset();
    set_req(0, 32'd1, 32'd2, 2'd0);
    set_req(1, 32'd3, 32'd4, 2'd0);
    req_valid = 4'b0011;
    #1;
    check("midrst_ready0", 32'(req_ready), 32'h1);
    tick();
    check("midrst_ready1", 32'(req_ready), 32'h2);
    tick();
    #3;
    reset = 1'b0;
    req_valid = 4'b0000;
    #1;
    check("midrst_out",       32'(outstanding), 32'd0);
    check("midrst_alu_valid", 32'(alu_valid), 32'd0);
    tick();
    reset = 1'b1;
    onehot = '0;
    for (int k = 0; k < 6; k++) begin
      tick();
      onehot |= resp_valid;
    end
    check("midrst_no_resp", 32'(onehot), 32'd0);
    check("midrst_out_after", 32'(outstanding), 32'd0);

    // ---------------- Response codes 0..3 pass through ----------------
    for (int c = 0; c < 4; c++) begin
      set_req(0, 32'h0000_00F0 + 32'(c), 32'h0000_0033, 2'(c));
      req_valid = 4'b0001;
      #1;
      tick();
      req_valid = 4'b0000;
      tick();
      tick();
      check("code_resp_valid", 32'(resp_valid), 32'h1);
      check("code_resp_resp",  32'(resp_response), 32'(c));
      check("code_resp_data",  resp_data, alu_fn(32'h0000_00F0 + 32'(c), 32'h33, 2'(c)));
    end
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_lane_scheduler.md
Name: alu_lane_scheduler

Overview:
- Shares one ALU packet lane among 4 requesters with round-robin arbitration.
- Each requester issues operations over a valid/ready handshake; granted operations are registered onto the lane.
- The lane's fixed result latency is tracked with a tag pipeline, and each result is routed back to the requester that issued it.
- Sits between requester logic and one input_packet/output_packet lane of the ALU.

Parameters:
- NUM_REQ, 4, number of requesters; fixed at 4 in this revision.
- ALU_LATENCY, 1, cycles from an issue beat on the alu_* outputs to the matching result on alu_data/alu_response; legal range 1..8.

Ports:
- clock  in  1  single clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  4  per-requester request valid.
- req_ready  out  4  per-requester grant; handshake occurs when req_valid[i] & req_ready[i] at a rising edge.
- req_data1  in  128  4x32 operand 1; requester i uses bits [32i+31:32i].
- req_data2  in  128  4x32 operand 2, same packing.
- req_command  in  8  4x2 command, same packing.
- alu_valid  out  1  issue beat present on the lane.
- alu_data1  out  32  operand 1 to the ALU lane.
- alu_data2  out  32  operand 2 to the ALU lane.
- alu_command  out  2  command to the ALU lane.
- alu_data  in  32  ALU lane result data.
- alu_response  in  2  ALU lane response code.
- resp_valid  out  4  one-cycle pulse: result for requester i.
- resp_data  out  32  result data, valid with any resp_valid bit.
- resp_response  out  2  response code, passed through unmodified.
- outstanding  out  4  bit i set while requester i has an operation in flight.

Behaviour:
- Reset (reset low, asynchronous):
  - alu_valid=0; alu_data1/alu_data2/alu_command=0.
  - resp_valid=0; resp_data=0; resp_response=0.
  - outstanding=0; tag pipeline cleared; round-robin pointer=3, so requester 0 has first priority.
- Eligibility: requester i is eligible when req_valid[i]=1 and outstanding[i]=0. Each requester has at most 1 operation in flight.
- Grant (combinational from registered state and req_valid):
  - At most one req_ready bit is high per cycle.
  - The search runs over eligible requesters starting at pointer+1 mod 4.
  - req_ready never asserts for a requester that is not eligible.
- Handshake edge for requester g:
  - alu_valid<=1; alu_data1/alu_data2/alu_command<= requester g's fields.
  - outstanding[g]<=1; pointer<=g.
  - Tag {valid=1, id=g} enters stage 0 of the tag pipeline.
- No handshake edge:
  - alu_valid<=0; alu_data1/alu_data2/alu_command<=0.
  - Pointer unchanged; a bubble tag {valid=0} enters the pipeline.
- Tag pipeline: ALU_LATENCY stages, shifting every cycle.
- Result capture: when the final-stage tag is valid with id k, the scheduler samples alu_data/alu_response at that edge, which is ALU_LATENCY cycles after the cycle alu_valid was high. At that edge:
  - resp_valid[k]<=1 (all other bits 0); resp_data<=alu_data; resp_response<=alu_response.
  - outstanding[k]<=0.
- Otherwise at each edge: resp_valid<=0; resp_data and resp_response hold their previous values.
- Latency: handshake at edge E → alu_valid high in cycle E..E+1 → resp_valid[k] high in the cycle following edge E+ALU_LATENCY+1.
- Same-edge resp and request: requester k is eligible again in the cycle resp_valid[k] is high, so back-to-back throughput per requester is one operation every ALU_LATENCY+2 cycles.
- Full utilisation: with 4 requesters and ALU_LATENCY<=2, the lane can accept an operation every cycle.
- Simultaneous issue and retire on one edge are independent; both take effect.
- req_valid deasserted after a handshake has no effect on the in-flight operation.
- Reset mid-operation: all in-flight tags are discarded and no resp_valid is produced for them. ALU results arriving after reset release are ignored because their tags were cleared.
- The command value is not decoded; every command, including one producing an error response, occupies the lane identically.

Test Plan:
- Reset release, single request: req_valid=4'b0001, data1=32'h0000_0003, data2=32'h0000_0004, command=2'd0, ALU_LATENCY=1 → req_ready[0] high in the same cycle; alu_valid high the next cycle with those operands; resp_valid=4'b0001 two cycles after the handshake with resp_data=alu_data; outstanding[0] clears on that edge.
- All four requesters hold req_valid=4'b1111 from reset → grants in order 0,1,2,3 on consecutive edges; tags return in the same order; each requester is re-granted the cycle its resp_valid pulses; no requester is granted twice while outstanding.
- Fairness: requesters 1 and 3 held continuously valid, pointer=1 → grant order 3,1,3,1…; requester 0 raised mid-sequence is granted within at most 2 handshakes.
- ALU_LATENCY=4: a single request from requester 2 → resp_valid[2] exactly 5 edges after the handshake; req_ready[2] stays low while outstanding[2]=1 even with req_valid[2] high.
- Reset asserted one cycle after two handshakes (requesters 0, 1) → outstanding=0 and alu_valid=0 immediately; no resp_valid pulse is ever produced for those operations after release.
- alu_response driven to each of 2'd0..2'd3 on successive operations → resp_response matches each value bit-for-bit in the corresponding resp_valid cycle.
